// File: rtl/rnn_loader_if.sv
// Parameter memory read port and accelerator register bus seen by rnn_loader.
// The master side drives addresses and strobes; the slave side returns data.
interface rnn_loader_if;
    logic [15:0] p_addr;
    logic [15:0] p_rdata;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport master (
        output p_addr, m_read, m_write, m_addr, m_wdata,
        input  p_rdata, m_rdata
    );

    modport slave (
        input  p_addr, m_read, m_write, m_addr, m_wdata,
        output p_rdata, m_rdata
    );
endinterface

// File: rtl/rnn_loader.sv
// Streams RNN parameters from word memory into the accelerator, kicks it,
// polls its status register until DONE or timeout, then releases it.
module rnn_loader #(
    parameter int IN_LEN   = 4,
    parameter int R0_ROWS  = 4,
    parameter int R0_COLS  = 16,
    parameter int R1_ROWS  = 16,
    parameter int R1_COLS  = 16,
    parameter int RB_LEN   = 8,
    parameter int D_LEN    = 16,
    parameter int POLL_MAX = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    output logic error,
    rnn_loader_if.master bus
);
    localparam int N = IN_LEN + R0_ROWS * R0_COLS + R1_ROWS * R1_COLS
                     + RB_LEN + D_LEN + 1;
    localparam int WW = $clog2(N + 1);
    localparam int PW = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, WRITE, KICK, POLL_REQ, POLL_WAIT, RELEASE
    } state_t;

    state_t        state;
    logic [WW-1:0] wcnt;
    logic [PW-1:0] pcnt;
    logic [2:0]    seg;
    logic [7:0]    row;
    logic [7:0]    col;
    logic [15:0]   hdr;
    logic [15:0]   p_addr_q;
    logic          m_read_q;
    logic          m_write_q;
    logic [2:0]    m_addr_q;
    logic [7:0]    seg_rows;
    logic [7:0]    seg_cols;
    logic          col_last;
    logic          row_last;
    logic          unused_rdata;

    // 1D tensors are treated as a single row so one row/col walker serves all
    always_comb begin
        seg_rows = 8'd1;
        seg_cols = 8'd1;
        case (seg)
            3'd1: seg_cols = 8'(IN_LEN);
            3'd2: begin
                seg_rows = 8'(R0_ROWS);
                seg_cols = 8'(R0_COLS);
            end
            3'd3: begin
                seg_rows = 8'(R1_ROWS);
                seg_cols = 8'(R1_COLS);
            end
            3'd4: seg_cols = 8'(RB_LEN);
            3'd5: seg_cols = 8'(D_LEN);
            default: ;
        endcase
    end

    assign col_last = (col == seg_cols - 8'd1);
    assign row_last = (row == seg_rows - 8'd1);

    assign bus.p_addr  = p_addr_q;
    assign bus.m_read  = m_read_q;
    assign bus.m_write = m_write_q;
    assign bus.m_addr  = {29'd0, m_addr_q};
    // memory data arrives in the WRITE cycle itself, so it bypasses the regs
    assign bus.m_wdata = {hdr, (state == WRITE) ? bus.p_rdata : 16'd0};
    assign unused_rdata = ^bus.m_rdata[31:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            wcnt      <= '0;
            pcnt      <= '0;
            seg       <= 3'd1;
            row       <= 8'd0;
            col       <= 8'd0;
            hdr       <= 16'd0;
            p_addr_q  <= 16'd0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= 3'd0;
        end else begin
            done      <= 1'b0;
            error     <= 1'b0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= 3'd0;
            hdr       <= 16'd0;
            case (state)
                IDLE: if (start) begin
                    state    <= FETCH;
                    busy     <= 1'b1;
                    wcnt     <= '0;
                    pcnt     <= '0;
                    seg      <= 3'd1;
                    row      <= 8'd0;
                    col      <= 8'd0;
                    p_addr_q <= 16'd0;
                end
                FETCH: begin
                    state     <= WRITE;
                    m_write_q <= 1'b1;
                    m_addr_q  <= seg;
                    hdr       <= {row, col};
                end
                WRITE: begin
                    wcnt <= wcnt + 1'b1;
                    if (col_last) begin
                        col <= 8'd0;
                        if (row_last) begin
                            row <= 8'd0;
                            seg <= seg + 3'd1;
                        end else begin
                            row <= row + 8'd1;
                        end
                    end else begin
                        col <= col + 8'd1;
                    end
                    if (wcnt == WW'(N - 1)) begin
                        state     <= KICK;
                        m_write_q <= 1'b1;
                    end else begin
                        state    <= FETCH;
                        p_addr_q <= 16'(wcnt + 1'b1);
                    end
                end
                KICK: begin
                    state    <= POLL_REQ;
                    m_read_q <= 1'b1;
                    pcnt     <= '0;
                end
                POLL_REQ: state <= POLL_WAIT;
                POLL_WAIT: begin
                    if (bus.m_rdata[1:0] == 2'b11) begin
                        state     <= RELEASE;
                        m_write_q <= 1'b1;
                    end else if (pcnt == PW'(POLL_MAX - 1)) begin
                        state <= IDLE;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state    <= POLL_REQ;
                        pcnt     <= pcnt + 1'b1;
                        m_read_q <= 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
